riscv_controller: RTL and testbench
===================================

Name: riscv_controller

Overview:
- Instruction-decode controller for the single-cycle RV32I subset core: lw, sw, add, sub, and, or, slt, beq, addi, jal, lui.
- Maps op/funct3/funct7 to datapath control strobes and a 3-bit ALU operation code.
- Decode is combinational (same-cycle).
- Adds a registered sticky illegal-instruction status for the core's debug/trap logic.

Parameters:
- None. Encodings are fixed constants in the shared package.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- instr_valid  input  1  current op/funct fields are a real fetched instruction
- op  input  7  instr[6:0]
- funct3  input  3  instr[14:12]
- funct7  input  7  instr[31:25]
- RegWrite  output  1  register-file write enable
- ALUSrc  output  1  ALU B operand: 1 = immediate, 0 = rs2
- Branch  output  1  conditional branch (taken when ALU result is zero)
- Jump  output  1  unconditional jump
- MemWrite  output  1  data-memory write enable
- Mem2Reg  output  1  writeback selects memory read data
- PC2Reg  output  1  writeback selects PC+4
- ALUControl  output  3  ALU operation
- illegal  output  1  combinational: current instruction is unsupported
- illegal_sticky  output  1  registered: set once any valid illegal instruction is seen

Behaviour:
- ALU codes: AND=000, OR=001, ADD=010, PASSB=011, SUB=110, SLT=111.
- Each instruction lists RegWrite, ALUSrc, ALUControl, Branch, Jump, MemWrite, Mem2Reg, PC2Reg. Any output not listed is 0.
- lw (op 0000011, f3 010): 1, 1, ADD, 0, 0, 0, 1, 0
- sw (op 0100011, f3 010): 0, 1, ADD, 0, 0, 1, 0, 0
- R-type (op 0110011): RegWrite 1, ALUSrc 0; rest 0 except ALUControl:
  - f7 0000000, f3 000: ADD
  - f7 0100000, f3 000: SUB
  - f7 0000000, f3 111: AND
  - f7 0000000, f3 110: OR
  - f7 0000000, f3 010: SLT
- beq (op 1100011, f3 000): 0, 0, SUB, 1, 0, 0, 0, 0
- addi (op 0010011, f3 000): 1, 1, ADD, rest 0; funct7 ignored.
- jal (op 1101111): RegWrite 1, ALUSrc 0, ADD, Jump 1, PC2Reg 1, rest 0; funct3/funct7 ignored.
- lui (op 0110111): 1, 1, PASSB, rest 0; funct3/funct7 ignored.
- Illegal instructions:
  - Any other op/funct3/funct7 combination, e.g. op 1100011 with f3 111, lw/sw with f3 ≠ 010, R-type with other funct7.
  - All control outputs 0, ALUControl 000, illegal=1.
  - illegal is 0 for every legal instruction.
- illegal does not depend on instr_valid.
- While reset=1: RegWrite and MemWrite are forced 0 combinationally; the other outputs still decode normally.
- illegal_sticky:
  - Reset value 0 at the clk edge with reset=1.
  - Set at clk edge when instr_valid & illegal & !reset.
  - Held until the next reset; reset wins over a simultaneous set.
- No other state. Decode latency is 0 cycles; illegal_sticky latency is 1 cycle.

Optional Feature:
- Macro: CTRL_ITYPE_ALU_EN
- Defined: op 0010011 additionally decodes
  - f3 111 = andi (AND)
  - f3 110 = ori (OR)
  - f3 010 = slti (SLT)
  - Each with RegWrite 1, ALUSrc 1, rest 0, illegal 0.
- Undefined: only f3 000 (addi) is legal under op 0010011; other funct3 values are illegal.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE, OP_JAL, OP_LUI
  - funct3/funct7 constants
  - alu_op_t enum with the six ALU codes
- Sub-module alu_decoder: funct3, funct7, a 2-bit ALUOp class (add / sub / funct-decoded / passb) in; ALUControl and a funct-legal flag out.
- The main decoder and the illegal_sticky register stay in riscv_controller.

Test Plan:
- lw (0000011, f3 010, f7 1110111): {RegWrite, ALUSrc, ALUControl, Branch, Jump, MemWrite, Mem2Reg, PC2Reg} = 11_010_00010, illegal 0.
- R-type sweep, op 0110011 (result → outputs):
  - add (f3 000, f7 0000000) → 10_010_00000
  - sub (f3 000, f7 0100000) → 10_110_00000
  - and (f3 111) → 10_000_00000
  - or (f3 110) → 10_001_00000
  - slt (f3 010) → 10_111_00000
- Stores, branch, immediates, jumps:
  - sw (f7 1010101) → 01_010_00100
  - beq (f3 000) → 00_110_10000
  - addi (f7 1111000) → 11_010_00000
  - jal (f3 111) → 10_010_01001
  - lui → 11_011_00000
- Illegal op 1100011, f3 111, instr_valid=1:
  - all outputs 0, illegal=1.
  - illegal_sticky rises at the next clk and stays 1 after returning to lw.
- Reset interactions:
  - reset=1 with lw applied: RegWrite=0, Mem2Reg=1.
  - reset=1 with sw applied: MemWrite=0.
  - illegal_sticky is 0 after the reset edge, including when an illegal instruction is present on that edge.
- op 0010011 with f3 111:
  - CTRL_ITYPE_ALU_EN defined: 11_000_00000, illegal 0.
  - Undefined: all 0, illegal 1.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I-subset decode controller: opcodes, funct fields,
// ALU operation codes and the ALU-operation class passed to alu_decoder.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_LW_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_AND   = 3'b000,
    ALU_OR    = 3'b001,
    ALU_ADD   = 3'b010,
    ALU_PASSB = 3'b011,
    ALU_SUB   = 3'b110,
    ALU_SLT   = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ACLS_ADD   = 2'b00,
    ACLS_SUB   = 2'b01,
    ACLS_FUNCT = 2'b10,
    ACLS_PASSB = 2'b11
  } alu_class_t;

  typedef struct packed {
    logic reg_write;
    logic alu_src;
    logic branch;
    logic jump;
    logic mem_write;
    logic mem2reg;
    logic pc2reg;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Second-level ALU decode: turns an ALU-operation class plus funct3/funct7 into
// the 3-bit ALU code, flagging funct combinations the core does not implement.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic [1:0] alu_class,
  output logic [2:0] ALUControl,
  output logic       funct_legal
);

  alu_op_t alu_op;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    alu_op      = ALU_AND;
    funct_legal = 1'b1;
    case (alu_class)
      ACLS_ADD:   alu_op = ALU_ADD;
      ACLS_SUB:   alu_op = ALU_SUB;
      ACLS_PASSB: alu_op = ALU_PASSB;
      ACLS_FUNCT: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD_SUB: alu_op = ALU_ADD;
            F3_AND:     alu_op = ALU_AND;
            F3_OR:      alu_op = ALU_OR;
            F3_SLT:     alu_op = ALU_SLT;
            default:    funct_legal = 1'b0;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          alu_op = ALU_SUB;
        end else begin
          funct_legal = 1'b0;
        end
      end
      default: funct_legal = 1'b0;
    endcase
  end

  assign ALUControl = alu_op;

endmodule

// File: rtl/riscv_controller.sv
// Single-cycle RV32I-subset decode controller with a sticky illegal-instruction flag.
// Define CTRL_ITYPE_ALU_EN to also decode andi/ori/slti under the I-type ALU opcode.
module riscv_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic       Branch,
  output logic       Jump,
  output logic       MemWrite,
  output logic       Mem2Reg,
  output logic       PC2Reg,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic       illegal_sticky
);

  ctrl_t      ctrl;
  alu_class_t alu_class;
  logic [6:0] funct7_dec;
  logic       op_legal;
  logic [2:0] alu_control_dec;
  logic       funct_legal;
  logic       illegal_sticky_d;
  logic       illegal_sticky_q;

  always_comb begin
    ctrl       = '0;
    alu_class  = ACLS_ADD;
    funct7_dec = funct7;
    op_legal   = 1'b0;
    case (op)
      OP_LOAD: if (funct3 == F3_LW_SW) begin
        op_legal       = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem2reg   = 1'b1;
      end
      OP_STORE: if (funct3 == F3_LW_SW) begin
        op_legal       = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_RTYPE: begin
        op_legal       = 1'b1;
        ctrl.reg_write = 1'b1;
        alu_class      = ACLS_FUNCT;
      end
      OP_BRANCH: if (funct3 == F3_BEQ) begin
        op_legal    = 1'b1;
        ctrl.branch = 1'b1;
        alu_class   = ACLS_SUB;
      end
      OP_ITYPE: begin
`ifdef CTRL_ITYPE_ALU_EN
        // Immediate forms carry no funct7; pin it so f3 000 always decodes as ADD.
        op_legal       = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        alu_class      = ACLS_FUNCT;
        funct7_dec     = F7_BASE;
`else
        if (funct3 == F3_ADD_SUB) begin
          op_legal       = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = 1'b1;
        end
`endif
      end
      OP_JAL: begin
        op_legal       = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.pc2reg    = 1'b1;
      end
      OP_LUI: begin
        op_legal       = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        alu_class      = ACLS_PASSB;
      end
      default: op_legal = 1'b0;
    endcase
  end

  alu_decoder u_alu_decoder (
    .funct3      (funct3),
    .funct7      (funct7_dec),
    .alu_class   (alu_class),
    .ALUControl  (alu_control_dec),
    .funct_legal (funct_legal)
  );

  assign illegal = !(op_legal && funct_legal);

  // Illegal instructions squash every strobe; reset additionally blocks all writes.
  always_comb begin
    RegWrite   = ctrl.reg_write & ~illegal & ~reset;
    MemWrite   = ctrl.mem_write & ~illegal & ~reset;
    ALUSrc     = ctrl.alu_src   & ~illegal;
    Branch     = ctrl.branch    & ~illegal;
    Jump       = ctrl.jump      & ~illegal;
    Mem2Reg    = ctrl.mem2reg   & ~illegal;
    PC2Reg     = ctrl.pc2reg    & ~illegal;
    ALUControl = illegal ? 3'b000 : alu_control_dec;
  end

  assign illegal_sticky_d = illegal_sticky_q | (instr_valid & illegal);

  // NOTE: state is updated with non-blocking assignment; the comb logic above uses blocking.
  always_ff @(posedge clk) begin
    if (reset) illegal_sticky_q <= 1'b0;
    else       illegal_sticky_q <= illegal_sticky_d;
  end

  assign illegal_sticky = illegal_sticky_q;

endmodule

// File: tb/tb_riscv_controller.sv
// Self-checking bench for riscv_controller: directed cases then random decode
// compared against a rule-table reference model with a sticky-flag model.
module tb_riscv_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       RegWrite, ALUSrc, Branch, Jump, MemWrite, Mem2Reg, PC2Reg;
  logic [2:0] ALUControl;
  logic       illegal, illegal_sticky;

  riscv_controller dut (
    .clk            (clk),
    .reset          (reset),
    .instr_valid    (instr_valid),
    .op             (op),
    .funct3         (funct3),
    .funct7         (funct7),
    .RegWrite       (RegWrite),
    .ALUSrc         (ALUSrc),
    .Branch         (Branch),
    .Jump           (Jump),
    .MemWrite       (MemWrite),
    .Mem2Reg        (Mem2Reg),
    .PC2Reg         (PC2Reg),
    .ALUControl     (ALUControl),
    .illegal        (illegal),
    .illegal_sticky (illegal_sticky)
  );

  always #5 clk = ~clk;

  // Legal instruction patterns; vec = {RegWrite, ALUSrc, ALUControl[2:0], Branch, Jump, MemWrite, Mem2Reg, PC2Reg}
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f3_care;
    logic [6:0] f7;
    logic       f7_care;
    logic [9:0] vec;
  } rule_t;

  rule_t rules[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  sticky_model = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (op=%b f3=%b f7=%b rst=%b)",
               tag, got, exp, op, funct3, funct7, reset);
    end
  endtask

  task automatic add_rule(input logic [6:0] o, input logic [2:0] f3, input logic f3c,
                          input logic [6:0] f7, input logic f7c, input logic [9:0] v);
    rule_t r;
    r.op = o; r.f3 = f3; r.f3_care = f3c; r.f7 = f7; r.f7_care = f7c; r.vec = v;
    rules.push_back(r);
  endtask

  function automatic void ref_decode(input logic [6:0] o, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic rst,
                                     output logic [9:0] vec, output logic ill);
    vec = '0;
    ill = 1'b1;
    foreach (rules[i]) begin
      if (ill && rules[i].op == o && (!rules[i].f3_care || rules[i].f3 == f3)
          && (!rules[i].f7_care || rules[i].f7 == f7)) begin
        vec = rules[i].vec;
        ill = 1'b0;
      end
    end
    if (rst) begin
      vec[9] = 1'b0;
      vec[2] = 1'b0;
    end
  endfunction

  // Apply one instruction for one cycle: check decode mid-cycle, sticky after the edge.
  task automatic apply(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic v, input logic rst, input string tag);
    logic [9:0] exp_vec;
    logic       exp_ill;
    @(negedge clk);
    op = o; funct3 = f3; funct7 = f7; instr_valid = v; reset = rst;
    #1;
    ref_decode(o, f3, f7, rst, exp_vec, exp_ill);
    check({tag, "_ctrl"}, 16'({RegWrite, ALUSrc, ALUControl, Branch, Jump, MemWrite, Mem2Reg, PC2Reg}),
          16'(exp_vec));
    check({tag, "_illegal"}, 16'(illegal), 16'(exp_ill));
    @(posedge clk);
    if (rst) sticky_model = 1'b0;
    else if (v && exp_ill) sticky_model = 1'b1;
    #1;
    check({tag, "_sticky"}, 16'(illegal_sticky), 16'(sticky_model));
  endtask

  logic [6:0] op_pool [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011,
                              7'b0010011, 7'b1101111, 7'b0110111, 7'b0000000};

  initial begin
    add_rule(7'b0000011, 3'b010, 1'b1, 7'h00, 1'b0, 10'b11_010_00010); // lw
    add_rule(7'b0100011, 3'b010, 1'b1, 7'h00, 1'b0, 10'b01_010_00100); // sw
    add_rule(7'b0110011, 3'b000, 1'b1, 7'b0000000, 1'b1, 10'b10_010_00000); // add
    add_rule(7'b0110011, 3'b000, 1'b1, 7'b0100000, 1'b1, 10'b10_110_00000); // sub
    add_rule(7'b0110011, 3'b111, 1'b1, 7'b0000000, 1'b1, 10'b10_000_00000); // and
    add_rule(7'b0110011, 3'b110, 1'b1, 7'b0000000, 1'b1, 10'b10_001_00000); // or
    add_rule(7'b0110011, 3'b010, 1'b1, 7'b0000000, 1'b1, 10'b10_111_00000); // slt
    add_rule(7'b1100011, 3'b000, 1'b1, 7'h00, 1'b0, 10'b00_110_10000); // beq
    add_rule(7'b0010011, 3'b000, 1'b1, 7'h00, 1'b0, 10'b11_010_00000); // addi
`ifdef CTRL_ITYPE_ALU_EN
    add_rule(7'b0010011, 3'b111, 1'b1, 7'h00, 1'b0, 10'b11_000_00000); // andi
    add_rule(7'b0010011, 3'b110, 1'b1, 7'h00, 1'b0, 10'b11_001_00000); // ori
    add_rule(7'b0010011, 3'b010, 1'b1, 7'h00, 1'b0, 10'b11_111_00000); // slti
`endif
    add_rule(7'b1101111, 3'b000, 1'b0, 7'h00, 1'b0, 10'b10_010_01001); // jal
    add_rule(7'b0110111, 3'b000, 1'b0, 7'h00, 1'b0, 10'b11_011_00000); // lui

    // Reset interactions, including an illegal instruction present on the reset edge.
    apply(7'b0000011, 3'b010, 7'b1110111, 1'b1, 1'b1, "rst_lw");
    apply(7'b0100011, 3'b010, 7'b1010101, 1'b1, 1'b1, "rst_sw");
    apply(7'b1100011, 3'b111, 7'b0000000, 1'b1, 1'b1, "rst_illegal");

    // Directed decode of every instruction class.
    apply(7'b0000011, 3'b010, 7'b1110111, 1'b1, 1'b0, "lw");
    apply(7'b0110011, 3'b000, 7'b0000000, 1'b1, 1'b0, "add");
    apply(7'b0110011, 3'b000, 7'b0100000, 1'b1, 1'b0, "sub");
    apply(7'b0110011, 3'b111, 7'b0000000, 1'b1, 1'b0, "and");
    apply(7'b0110011, 3'b110, 7'b0000000, 1'b1, 1'b0, "or");
    apply(7'b0110011, 3'b010, 7'b0000000, 1'b1, 1'b0, "slt");
    apply(7'b0100011, 3'b010, 7'b1010101, 1'b1, 1'b0, "sw");
    apply(7'b1100011, 3'b000, 7'b0000000, 1'b1, 1'b0, "beq");
    apply(7'b0010011, 3'b000, 7'b1111000, 1'b1, 1'b0, "addi");
    apply(7'b1101111, 3'b111, 7'b0000000, 1'b1, 1'b0, "jal");
    apply(7'b0110111, 3'b101, 7'b0011001, 1'b1, 1'b0, "lui");
    apply(7'b0010011, 3'b111, 7'b0000000, 1'b0, 1'b0, "itype_f3_111");
    apply(7'b0110011, 3'b111, 7'b0100000, 1'b0, 1'b0, "rtype_bad_f7");
    apply(7'b1100011, 3'b111, 7'b0000000, 1'b1, 1'b0, "illegal_beq");
    apply(7'b0000011, 3'b010, 7'b0000000, 1'b1, 1'b0, "lw_after_illegal");
    apply(7'b0000011, 3'b010, 7'b0000000, 1'b1, 1'b1, "rst_clear");

    // Randomized decode with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic [6:0] o;
      logic [6:0] f7;
      int         pick;
      pick = int'($urandom_range(0, 8));
      o = (pick == 8) ? 7'($urandom) : op_pool[pick];
      case ($urandom_range(0, 3))
        0:       f7 = 7'b0000000;
        1:       f7 = 7'b0100000;
        default: f7 = 7'($urandom);
      endcase
      apply(o, 3'($urandom), f7, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
